// File: rtl/prim_arb_ingress.sv
// prim_arb_ingress
// ----------------
// Per-requester ingress buffer placed directly in front of the round-robin
// arbiter. Each of the N source channels owns a small FIFO of Depth entries.
// The head entry of each non-empty FIFO is presented to the arbiter as a
// request plus data. The head is popped when the arbiter grant returns.
//
// Handshake: a source beat is accepted when src_valid_i[i] & src_ready_o[i].
// An arbiter beat is consumed when gnt_i[i] & req_o[i]. Ready and request are
// both derived purely from registered occupancy. There is no combinational
// path from src_valid_i or gnt_i to any output. For that reason a full
// channel cannot accept a push in the same cycle that it pops.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   src_valid_i[N]      per-channel push request
//   src_ready_o[N]      per-channel space available (count < Depth)
//   src_data_i[N*DW]    channel i data at [i*DW +: DW]
//   req_o[N]            channel i non-empty
//   data_o[N*DW]        channel i head entry, zero when the channel is empty
//   gnt_i[N]            arbiter grant, pops the head of each granted channel
//   depth_o[N*CW]       channel i occupancy at [i*CW +: CW]
//   gnt_err_o           one-cycle registered pulse: grant to an empty channel
module prim_arb_ingress #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int Depth = 2,
    parameter int CW    = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      src_valid_i,
    output logic [N-1:0]      src_ready_o,
    input  logic [N*DW-1:0]   src_data_i,
    output logic [N-1:0]      req_o,
    output logic [N*DW-1:0]   data_o,
    input  logic [N-1:0]      gnt_i,
    output logic [N*CW-1:0]   depth_o,
    output logic              gnt_err_o
);

    // The pointer width is kept at a minimum of one bit so that the
    // declarations stay legal. Depth == 1 does not use pointers at all.
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [CW-1:0] count_q, count_d;
        logic          push, pop;
        logic [DW-1:0] head;

        always_comb begin
            push    = src_valid_i[g] & src_ready_o[g];
            pop     = gnt_i[g] & req_o[g];
            count_d = count_q;
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                count_q <= '0;
            end else begin
                count_q <= count_d;
            end
        end

        if (Depth == 1) begin : g_reg
            // A single entry: the count doubles as the valid bit.
            logic [DW-1:0] mem_q;

            // The storage is deliberately not reset. The data are qualified by count.
            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem_q <= src_data_i[g*DW +: DW];
                end
            end

            assign head = mem_q;
        end else begin : g_fifo
            logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
            logic [DW-1:0] mem_q [Depth];

            // The pointers wrap modulo Depth. Depth need not be a power of two.
            always_comb begin
                wptr_d = wptr_q;
                rptr_d = rptr_q;
                if (push) begin
                    wptr_d = (wptr_q == PW'(Depth - 1)) ? '0 : wptr_q + PW'(1);
                end
                if (pop) begin
                    rptr_d = (rptr_q == PW'(Depth - 1)) ? '0 : rptr_q + PW'(1);
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    wptr_q <= wptr_d;
                    rptr_q <= rptr_d;
                end
            end

            always_ff @(posedge clk_i) begin
                if (push) begin
                    mem_q[wptr_q] <= src_data_i[g*DW +: DW];
                end
            end

            assign head = mem_q[rptr_q];
        end

        assign src_ready_o[g]          = (count_q < CW'(Depth));
        assign req_o[g]                = (count_q != '0);
        assign data_o[g*DW +: DW]      = req_o[g] ? head : '0;
        assign depth_o[g*CW +: CW]     = count_q;
    end

    // Any grant to an empty channel is flagged. Several such grants in one
    // cycle still collapse into a single pulse.
    logic gnt_err_q, gnt_err_d;

    always_comb begin
        gnt_err_d = |(gnt_i & ~req_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

    assign gnt_err_o = gnt_err_q;

endmodule

// File: tb/tb_prim_arb_ingress.sv
// Directed testbench for prim_arb_ingress. The default build is N=4, DW=32,
// Depth=2. A second instance is an N=1, DW=8, Depth=1 build.
module tb_prim_arb_ingress;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    // ---------------- default build ----------------
    logic [3:0]   src_valid_i;
    logic [3:0]   src_ready_o;
    logic [127:0] src_data_i;
    logic [3:0]   req_o;
    logic [127:0] data_o;
    logic [3:0]   gnt_i;
    logic [7:0]   depth_o;
    logic         gnt_err_o;

    prim_arb_ingress #(.N(4), .DW(32), .Depth(2)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_data_i  (src_data_i),
        .req_o       (req_o),
        .data_o      (data_o),
        .gnt_i       (gnt_i),
        .depth_o     (depth_o),
        .gnt_err_o   (gnt_err_o)
    );

    // ---------------- N=1, Depth=1 build ----------------
    logic [0:0] s1_valid, s1_ready, s1_req, s1_gnt, s1_depth;
    logic [7:0] s1_data_in, s1_data_out;
    logic       s1_err;

    prim_arb_ingress #(.N(1), .DW(8), .Depth(1)) u_dut1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (s1_valid),
        .src_ready_o (s1_ready),
        .src_data_i  (s1_data_in),
        .req_o       (s1_req),
        .data_o      (s1_data_out),
        .gnt_i       (s1_gnt),
        .depth_o     (s1_depth),
        .gnt_err_o   (s1_err)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge. Outputs are sampled at that point.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] val);
        src_data_i[ch*32 +: 32] = val;
    endtask

    function automatic logic [31:0] head(input int ch);
        return data_o[ch*32 +: 32];
    endfunction

    function automatic logic [1:0] dep(input int ch);
        return depth_o[ch*2 +: 2];
    endfunction

    initial begin
        rst_ni      = 1'b0;
        src_valid_i = '0;
        src_data_i  = '0;
        gnt_i       = '0;
        s1_valid    = '0;
        s1_data_in  = '0;
        s1_gnt      = '0;
        #1;
        check_val("rst_req",   64'(req_o),       64'h0);
        check_val("rst_ready", 64'(src_ready_o), 64'hf);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        check_val("idle_req",   64'(req_o),       64'h0);
        check_val("idle_ready", 64'(src_ready_o), 64'hf);
        check_val("idle_data",  64'(data_o != '0), 64'h0);
        check_val("idle_depth", 64'(depth_o),     64'h0);
        check_val("idle_err",   64'(gnt_err_o),   64'h0);

        // Single beat on channel 2, then a grant pops it.
        src_valid_i = 4'b0100;
        set_data(2, 32'hA5A5_0001);
        step();
        src_valid_i = '0;
        check_val("c2_req",   64'(req_o),   64'h4);
        check_val("c2_data",  64'(head(2)), 64'hA5A5_0001);
        check_val("c2_depth", 64'(depth_o), 64'h10);
        gnt_i = 4'b0100;
        step();
        gnt_i = '0;
        check_val("c2_req_pop", 64'(req_o),     64'h0);
        check_val("c2_dep_pop", 64'(depth_o),   64'h0);
        check_val("c2_err_pop", 64'(gnt_err_o), 64'h0);

        // Channel 0 fills and stalls, and is then drained in order.
        src_valid_i = 4'b0001;
        set_data(0, 32'h11);
        step();
        set_data(0, 32'h22);
        step();
        set_data(0, 32'h33);
        check_val("c0_full_rdy", 64'(src_ready_o[0]), 64'h0);
        check_val("c0_full_dep", 64'(dep(0)),         64'h2);
        step();
        check_val("c0_stall_dep",  64'(dep(0)),  64'h2);
        check_val("c0_stall_head", 64'(head(0)), 64'h11);
        gnt_i = 4'b0001;
        step();
        gnt_i = '0;
        check_val("c0_pop_head", 64'(head(0)),         64'h22);
        check_val("c0_pop_dep",  64'(dep(0)),          64'h1);
        check_val("c0_pop_rdy",  64'(src_ready_o[0]),  64'h1);
        step();
        src_valid_i = '0;
        check_val("c0_acc_dep",  64'(dep(0)),  64'h2);
        check_val("c0_acc_head", 64'(head(0)), 64'h22);
        gnt_i = 4'b0001;
        step();
        check_val("c0_head_33", 64'(head(0)), 64'h33);
        step();
        gnt_i = '0;
        check_val("c0_empty_req", 64'(req_o[0]), 64'h0);
        check_val("c0_empty_dep", 64'(dep(0)),   64'h0);

        // A full channel 1 gets valid and grant in the same cycle. The pop occurs and the push is refused.
        src_valid_i = 4'b0010;
        set_data(1, 32'h101);
        step();
        set_data(1, 32'h102);
        step();
        set_data(1, 32'h103);
        gnt_i = 4'b0010;
        step();
        src_valid_i = '0;
        gnt_i       = '0;
        check_val("c1_dep",  64'(dep(1)),  64'h1);
        check_val("c1_head", 64'(head(1)), 64'h102);
        gnt_i = 4'b0010;
        step();
        gnt_i = '0;
        check_val("c1_drain", 64'(dep(1)), 64'h0);

        // Steady stream on channel 3 at depth 1 across the pointer wrap.
        src_valid_i = 4'b1000;
        set_data(3, 32'h300);
        step();
        for (int k = 1; k <= 10; k++) begin
            set_data(3, 32'h300 + 32'(k));
            gnt_i = 4'b1000;
            check_val("c3_head", 64'(head(3)),        64'(32'h300 + 32'(k - 1)));
            check_val("c3_rdy",  64'(src_ready_o[3]), 64'h1);
            step();
            check_val("c3_dep",  64'(dep(3)),         64'h1);
        end
        src_valid_i = '0;
        check_val("c3_last", 64'(head(3)), 64'h30A);
        step();
        gnt_i = '0;
        check_val("c3_drain", 64'(depth_o), 64'h0);

        // A grant to empty channel 3 produces a one-cycle error pulse.
        gnt_i = 4'b1000;
        step();
        gnt_i = '0;
        check_val("err_pulse", 64'(gnt_err_o), 64'h1);
        check_val("err_depth", 64'(depth_o),   64'h0);
        check_val("err_req",   64'(req_o),     64'h0);
        step();
        check_val("err_clear", 64'(gnt_err_o), 64'h0);
        gnt_i = 4'b1111;
        step();
        gnt_i = '0;
        check_val("err_multi", 64'(gnt_err_o), 64'h1);
        step();
        check_val("err_multi_clr", 64'(gnt_err_o), 64'h0);

        // N=1, Depth=1 build: push and pop alternate.
        s1_valid   = 1'b1;
        s1_data_in = 8'h5A;
        step();
        s1_data_in = 8'h6B;
        s1_gnt     = 1'b1;
        check_val("s1_req",   64'(s1_req),      64'h1);
        check_val("s1_ready", 64'(s1_ready),    64'h0);
        check_val("s1_data",  64'(s1_data_out), 64'h5A);
        check_val("s1_depth", 64'(s1_depth),    64'h1);
        step();
        s1_gnt = 1'b0;
        check_val("s1_pop_req", 64'(s1_req),   64'h0);
        check_val("s1_pop_rdy", 64'(s1_ready), 64'h1);
        step();
        s1_valid = 1'b0;
        check_val("s1_data2", 64'(s1_data_out), 64'h6B);
        s1_gnt = 1'b1;
        step();
        s1_gnt = 1'b0;
        check_val("s1_empty", 64'(s1_depth), 64'h0);

        // Reset asserted mid-traffic discards the buffered entries at once.
        src_valid_i = 4'b0011;
        set_data(0, 32'hDEAD_0000);
        set_data(1, 32'hBEEF_0000);
        step();
        check_val("mid_req_pre", 64'(req_o), 64'h3);
        rst_ni = 1'b0;
        #1;
        check_val("mid_req",   64'(req_o),        64'h0);
        check_val("mid_ready", 64'(src_ready_o),  64'hf);
        check_val("mid_depth", 64'(depth_o),      64'h0);
        check_val("mid_data",  64'(data_o != '0), 64'h0);
        src_valid_i = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        check_val("post_rst_req", 64'(req_o), 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/prim_arb_ingress.md
Name: prim_arb_ingress

Overview:
- Per-requester ingress buffer that sits directly upstream of the round-robin arbiter in the SoC interconnect.
- Provides N independent small FIFOs, one per source. Each FIFO accepts a valid/ready stream from its source.
- Each channel presents its head entry as a request plus data to the arbiter. It pops when the arbiter's grant returns.
- Decouples sources from arbitration stalls and registers the request path.

Parameters:
- N, 4: number of source channels (>=1).
- DW, 32: data width per channel.
- Depth, 2: entries per channel FIFO (>=1; need not be a power of two).
- CW, $clog2(Depth+1): derived occupancy counter width. Not overridden.

Ports:
- clk_i, in, 1: clock; all state on rising edge.
- rst_ni, in, 1: asynchronous active-low reset.
- src_valid_i, in, N: per-channel push request.
- src_ready_o, out, N: per-channel space available.
- src_data_i, in, N*DW: channel i data at bits [i*DW +: DW].
- req_o, out, N: channel i non-empty; drives arbiter req_i.
- data_o, out, N*DW: head entry of channel i at [i*DW +: DW]; drives arbiter data_i.
- gnt_i, in, N: arbiter grant; pops the head of each granted channel.
- depth_o, out, N*CW: occupancy of channel i at [i*CW +: CW].
- gnt_err_o, out, 1: registered pulse, grant to an empty channel.

Behaviour:
- Reset (asynchronous, active-low):
  - All counts, read pointers and write pointers go to 0.
  - req_o=0, data_o=0, depth_o=0, gnt_err_o=0, src_ready_o=all ones.
  - Storage array is not reset. Deassertion is synchronous to clk_i by the integration level.
- Reset asserted mid-operation: all buffered entries are discarded immediately. No output glitches beyond the reset values.
- Per channel i, decode:
  - push_i = src_valid_i[i] & src_ready_o[i]
  - pop_i = gnt_i[i] & req_o[i]
- src_ready_o[i] = (count_i < Depth). Depends only on registered count, never on gnt_i; no combinational ready-through path.
- req_o[i] = (count_i != 0). Registered-derived, no combinational path from src_valid_i.
- data_o channel i = storage[rptr_i] when count_i != 0, else all zeros.
- Latency: data pushed in cycle t appears on req_o/data_o in cycle t+1. No fall-through or bypass when empty.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - neither: unchanged
- Full channel (count=Depth): src_ready_o[i]=0, so a same-cycle pop does not admit a push. Space reappears the cycle after the pop.
- Empty channel with a same-cycle push: entry is written, req_o rises next cycle.
- Pointers:
  - wptr advances on push, rptr advances on pop.
  - Each wraps from Depth-1 to 0 (modulo Depth, not power-of-two masking).
  - Depth=1 degenerates to a single register with a valid bit.
- Grant handling:
  - gnt_i is one-hot or zero in normal use. Multi-hot is tolerated: each granted non-empty channel pops independently.
  - A grant with gnt_i[i]=1 while count_i=0 is ignored, with no state change. gnt_err_o=1 in the following cycle only.
  - If several channels are granted while empty, gnt_err_o is still a single-bit pulse.
- Channels are fully independent: no cross-channel ordering or priority.
- depth_o reflects registered count_i. Range 0..Depth.

Test Plan:
- Reset, then idle: req_o=0, src_ready_o=4'b1111, data_o=0, depth_o=0. Assert rst_ni low mid-traffic -> same values immediately.
- Push 0xA5A5_0001 on channel 2 in cycle t, gnt_i=0 -> req_o=4'b0100 at t+1, data_o ch2=0xA5A5_0001, depth ch2=1. gnt_i=4'b0100 at t+1 -> req_o=0 at t+2.
- Depth=2, ch0 pushes 0x11, 0x22, 0x33 back-to-back, no grants -> third beat stalls (src_ready_o[0]=0, depth=2). Grant once -> head 0x22, ready 1 next cycle, 0x33 accepted after that. Pops return 0x22, 0x33 in order.
- Full ch1 with same-cycle valid and grant -> pop occurs, push refused, depth goes 2->1.
- Steady stream on ch3 with push and grant every cycle at depth 1 -> depth stays 1, throughput 1/cycle. Data order is preserved across pointer wrap for 10 beats.
- gnt_i=4'b1000 with ch3 empty -> gnt_err_o=1 for exactly one cycle, all counts unchanged. N=1, Depth=1 build: push/pop alternate correctly.
